// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared snake game coordinate types and collision detector states
package snake_pkg;

  localparam int COORD_W    = 4;
  localparam int GRID_MAX   = 15;
  localparam int MAX_LENGTH = 50;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SCAN,
    CMP,
    REPORT
  } cd_state_t;

endpackage

// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - per-move head vs apple/wall/body check, one verdict pulse per move
import snake_pkg::*;

module collision_detector (
  input  logic               clk,
  input  logic               nRst,
  input  logic               moveStrobe,
  input  logic [COORD_W-1:0] headX,
  input  logic [COORD_W-1:0] headY,
  input  logic [COORD_W-1:0] appleX,
  input  logic [COORD_W-1:0] appleY,
  input  logic [6:0]         bodyLen,
  output logic [6:0]         segAddr,
  input  logic [COORD_W-1:0] segX,
  input  logic [COORD_W-1:0] segY,
  output logic               busy,
  output logic               goodColl,
  output logic               badColl
);

  localparam logic [COORD_W-1:0] GRID_MAX_C = COORD_W'(GRID_MAX);
  localparam logic [6:0]         MAX_LEN_C  = 7'(MAX_LENGTH);

  cd_state_t  state_q, state_d;
  coord_t     head_q, head_d;
  coord_t     apple_q, apple_d;
  logic [6:0] len_q, len_d;
  logic [6:0] idx_q, idx_d;
  logic [6:0] seg_addr_q, seg_addr_d;
  logic       wall_q, wall_d;
  logic       apple_hit_q, apple_hit_d;
  logic       body_q, body_d;
  logic       good_q, good_d;
  logic       bad_q, bad_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    apple_d     = apple_q;
    len_d       = len_q;
    idx_d       = idx_q;
    seg_addr_d  = seg_addr_q;
    wall_d      = wall_q;
    apple_hit_d = apple_hit_q;
    body_d      = body_q;
    good_d      = 1'b0;
    bad_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (moveStrobe) begin
          head_d      = '{x: headX, y: headY};
          apple_d     = '{x: appleX, y: appleY};
          // A zero length still means the head exists on its own.
          if (bodyLen > MAX_LEN_C)  len_d = MAX_LEN_C;
          else if (bodyLen == 7'd0) len_d = 7'd1;
          else                      len_d = bodyLen;
          idx_d       = 7'd1;
          wall_d      = 1'b0;
          apple_hit_d = 1'b0;
          body_d      = 1'b0;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        wall_d = (head_q.x == '0) || (head_q.x == GRID_MAX_C) ||
                 (head_q.y == '0) || (head_q.y == GRID_MAX_C);
        apple_hit_d = (head_q == apple_q);
        if (wall_d || (len_q <= 7'd1)) state_d = REPORT;
        else                           state_d = SCAN;
      end
      SCAN: state_d = CMP;
      CMP: begin
        if ((segX == head_q.x) && (segY == head_q.y)) begin
          body_d  = 1'b1;
          state_d = REPORT;
        end else if (idx_q == len_q - 7'd1) begin
          state_d = REPORT;
        end else begin
          idx_d   = idx_q + 7'd1;
          state_d = SCAN;
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Address and verdict are registered on entry so they are visible in SCAN/REPORT.
    if (state_d == SCAN) seg_addr_d = idx_d;
    if (state_d == REPORT) begin
      bad_d  = wall_d | body_d;
      good_d = apple_hit_d & ~bad_d;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      apple_q     <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      seg_addr_q  <= '0;
      wall_q      <= 1'b0;
      apple_hit_q <= 1'b0;
      body_q      <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      apple_q     <= apple_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      seg_addr_q  <= seg_addr_d;
      wall_q      <= wall_d;
      apple_hit_q <= apple_hit_d;
      body_q      <= body_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      busy_q      <= busy_d;
    end
  end

  assign segAddr  = seg_addr_q;
  assign busy     = busy_q;
  assign goodColl = good_q;
  assign badColl  = bad_q;

endmodule

// File: tb/tb_collision_detector.sv
// tb/tb_collision_detector.sv - directed table-driven bench for collision_detector
module tb_collision_detector;

  logic       clk;
  logic       nRst;
  logic       moveStrobe;
  logic [3:0] headX, headY, appleX, appleY;
  logic [6:0] bodyLen;
  logic [6:0] segAddr;
  logic [3:0] segX, segY;
  logic       busy, goodColl, badColl;

  logic [3:0] mem_x [0:127];
  logic [3:0] mem_y [0:127];

  int total = 0;
  int n_bad = 0;

  collision_detector dut (
    .clk(clk), .nRst(nRst), .moveStrobe(moveStrobe),
    .headX(headX), .headY(headY), .appleX(appleX), .appleY(appleY),
    .bodyLen(bodyLen), .segAddr(segAddr), .segX(segX), .segY(segY),
    .busy(busy), .goodColl(goodColl), .badColl(badColl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Body store model: one-cycle registered read port.
  always @(posedge clk) begin
    segX <= mem_x[segAddr];
    segY <= mem_y[segAddr];
  end

  typedef struct {
    logic [3:0] hx, hy, ax, ay;
    logic [6:0] len;
    int         hit_seg;
    int         exp_good;
    int         exp_bad;
    int         exp_lat;
    int         exp_max;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    nRst = 1'b0;
    moveStrobe = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_move(input vec_t v, input int extra, input string tag);
    int cnt, gc, bc, pulse_at, last_busy, maxa, done, idle_busy;
    for (int k = 0; k < 128; k++) begin
      mem_x[k] = 4'd1;
      mem_y[k] = 4'd1;
    end
    if (v.hit_seg > 0) begin
      mem_x[v.hit_seg] = v.hx;
      mem_y[v.hit_seg] = v.hy;
    end
    apply_reset();
    headX = v.hx; headY = v.hy; appleX = v.ax; appleY = v.ay; bodyLen = v.len;
    moveStrobe = 1'b1;
    cnt = 0; gc = 0; bc = 0; pulse_at = 0; last_busy = 0; maxa = 0; done = 0;
    while (!done && cnt < 300) begin
      @(negedge clk);
      cnt++;
      if (goodColl) begin gc++; pulse_at = cnt; end
      if (badColl)  begin bc++; pulse_at = cnt; end
      if (busy) last_busy = cnt;
      if (int'(segAddr) > maxa) maxa = int'(segAddr);
      if (!busy) done = 1;
      moveStrobe = (cnt == extra);
    end
    moveStrobe = 1'b0;
    check({tag, "_finished"}, done, 1);
    check({tag, "_good_count"}, gc, v.exp_good);
    check({tag, "_bad_count"}, bc, v.exp_bad);
    check({tag, "_busy_last_cycle"}, last_busy, v.exp_lat);
    check({tag, "_pulse_cycle"}, pulse_at, (v.exp_good + v.exp_bad > 0) ? v.exp_lat : 0);
    check({tag, "_max_segaddr"}, maxa, v.exp_max);
    idle_busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || goodColl || badColl) idle_busy++;
    end
    check({tag, "_stays_idle"}, idle_busy, 0);
  endtask

  initial begin
    int pulses;
    nRst = 1'b0; moveStrobe = 1'b0;
    headX = '0; headY = '0; appleX = '0; appleY = '0; bodyLen = '0;
    for (int k = 0; k < 128; k++) begin mem_x[k] = 4'd1; mem_y[k] = 4'd1; end

    //            hx     hy     ax     ay     len     hit good bad lat max
    vecs[0]  = '{4'd5,  4'd5,  4'd5,  4'd5,  7'd1,   0,  1,   0,  2,   0};
    vecs[1]  = '{4'd0,  4'd7,  4'd0,  4'd7,  7'd3,   0,  0,   1,  2,   0};
    vecs[2]  = '{4'd4,  4'd4,  4'd1,  4'd2,  7'd4,   2,  0,   1,  6,   2};
    vecs[3]  = '{4'd8,  4'd8,  4'd2,  4'd2,  7'd4,   0,  0,   0,  8,   3};
    vecs[4]  = '{4'd7,  4'd7,  4'd3,  4'd3,  7'd100, 0,  0,   0,  100, 49};
    vecs[5]  = '{4'd6,  4'd6,  4'd6,  4'd6,  7'd0,   0,  1,   0,  2,   0};
    vecs[6]  = '{4'd15, 4'd3,  4'd2,  4'd2,  7'd1,   0,  0,   1,  2,   0};
    vecs[7]  = '{4'd9,  4'd9,  4'd9,  4'd9,  7'd5,   1,  0,   1,  4,   1};
    vecs[8]  = '{4'd10, 4'd4,  4'd10, 4'd4,  7'd3,   0,  1,   0,  6,   2};
    vecs[9]  = '{4'd3,  4'd0,  4'd9,  4'd9,  7'd6,   0,  0,   1,  2,   0};
    vecs[10] = '{4'd12, 4'd13, 4'd1,  4'd1,  7'd50,  49, 0,   1,  100, 49};
    vecs[11] = '{4'd2,  4'd14, 4'd2,  4'd14, 7'd2,   0,  1,   0,  4,   1};
    vecs[12] = '{4'd11, 4'd11, 4'd5,  4'd5,  7'd3,   3,  0,   0,  6,   2};

    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_good", int'(goodColl), 0);
    check("reset_bad", int'(badColl), 0);
    check("reset_segaddr", int'(segAddr), 0);
    nRst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_move(vecs[i], 0, $sformatf("vec%0d", i));

    // Strobe in the middle of a move and in the REPORT cycle must both be dropped.
    run_move(vecs[3], 3, "strobe_while_busy");
    run_move(vecs[0], 2, "strobe_in_report");

    // Reset while the scan is in progress aborts without any pulse.
    for (int k = 0; k < 128; k++) begin mem_x[k] = 4'd1; mem_y[k] = 4'd1; end
    apply_reset();
    headX = 4'd8; headY = 4'd8; appleX = 4'd8; appleY = 4'd8; bodyLen = 7'd4;
    moveStrobe = 1'b1;
    @(negedge clk);
    moveStrobe = 1'b0;
    @(negedge clk);
    check("midscan_segaddr_before_reset", int'(segAddr), 1);
    nRst = 1'b0;
    #1;
    check("midscan_reset_busy", int'(busy), 0);
    check("midscan_reset_segaddr", int'(segAddr), 0);
    check("midscan_reset_pulses", int'(goodColl) + int'(badColl), 0);
    @(negedge clk);
    nRst = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || goodColl || badColl) pulses++;
    end
    check("midscan_no_activity_after_release", pulses, 0);

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule
